// File: rtl/sdram_pkg.sv
// Shared definitions for the two-port SDRAM arbiter: FSM encoding, port count
// and the default host address width.
package sdram_pkg;

  localparam int NPORTS          = 2;
  localparam int HADDR_WIDTH_DEF = 25;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_e;

  function automatic logic [NPORTS-1:0] port_mask(input logic idx);
    port_mask = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection between the two requesters. On a tie the
// port that was not granted last wins.
module sdram_arb_pick
  import sdram_pkg::*;
(
  input  logic [NPORTS-1:0] req_i,
  input  logic              last_grant_i,
  output logic              grant_o
);

  always_comb begin
    grant_o = 1'b0;
    if (req_i[0]) begin
      grant_o = req_i[1] & ~last_grant_i;
    end else begin
      grant_o = req_i[1];
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of a single-transaction SDRAM controller.
// Define SDRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority (port 0).
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int HADDR_WIDTH = HADDR_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        p_req,
  input  logic [NPORTS-1:0]        p_we,
  input  logic [2*HADDR_WIDTH-1:0] p_addr,
  input  logic [15:0]              p_wdata,
  output logic [NPORTS-1:0]        p_ack,
  output logic [7:0]               p_rdata,
  output logic [NPORTS-1:0]        p_rvalid,
  output logic [HADDR_WIDTH-1:0]   sd_wr_addr,
  output logic [HADDR_WIDTH-1:0]   sd_rd_addr,
  output logic [7:0]               sd_wr_data,
  output logic                     sd_wr_enable,
  output logic                     sd_rd_enable,
  input  logic                     sd_ack,
  input  logic                     sd_rd_ready,
  input  logic                     sd_busy,
  input  logic [7:0]               sd_rd_data
);

  state_e                   state_q, state_d;
  logic                     grant_q, grant_d;
  logic                     we_q, we_d;
  logic [HADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]               wdata_q, wdata_d;
  logic [7:0]               rdata_q, rdata_d;
  logic [NPORTS-1:0]        rvalid_q, rvalid_d;
  logic                     pick;
  logic                     last_grant;
  logic                     unused_busy;

  // Refresh stalls are expressed through sd_ack latency, so busy is not consulted.
  assign unused_busy = sd_busy;

`ifdef SDRAM_ARB_RR_EN
  logic last_q, last_d;
  assign last_grant = last_q;
`else
  // A pointer stuck at 1 makes the picker favour port 0 on every tie.
  assign last_grant = 1'b1;
`endif

  sdram_arb_pick u_pick (
    .req_i        (p_req),
    .last_grant_i (last_grant),
    .grant_o      (pick)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
`ifdef SDRAM_ARB_RR_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|p_req) begin
          grant_d = pick;
          we_d    = p_we[pick];
          addr_d  = pick ? p_addr[2*HADDR_WIDTH-1:HADDR_WIDTH] : p_addr[HADDR_WIDTH-1:0];
          wdata_d = pick ? p_wdata[15:8] : p_wdata[7:0];
          state_d = ISSUE;
`ifdef SDRAM_ARB_RR_EN
          last_d  = pick;
`endif
        end
      end
      ISSUE: begin
        if (sd_ack) begin
          state_d = we_q ? IDLE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (sd_rd_ready) begin
          rdata_d  = sd_rd_data;
          rvalid_d = port_mask(grant_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

`ifdef SDRAM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Enables are decoded from the registered state so they drop on the edge after sd_ack.
  assign sd_wr_enable = (state_q == ISSUE) &  we_q;
  assign sd_rd_enable = (state_q == ISSUE) & ~we_q;
  assign sd_wr_addr   = addr_q;
  assign sd_rd_addr   = addr_q;
  assign sd_wr_data   = wdata_q;
  assign p_ack        = ((state_q == ISSUE) && sd_ack) ? port_mask(grant_q) : '0;
  assign p_rdata      = rdata_q;
  assign p_rvalid     = rvalid_q;

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter HADDR_WIDTH, default 25, host byte-address width: bank+row+col.
REQ-002 SHALL have port clk, input, 1, single clock for all logic.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port p_req, input, 2, per-port request; held until p_ack.
REQ-005 SHALL have port p_we, input, 2, per-port 1=write, 0=read; stable while p_req.
REQ-006 SHALL have port p_addr, input, 2*HADDR_WIDTH, port i in slice [i*HADDR_WIDTH +: HADDR_WIDTH].
REQ-007 SHALL have port p_wdata, input, 16, port i byte in [i*8 +: 8].
REQ-008 SHALL have port p_ack, output, 2, one-cycle request-accepted pulse.
REQ-009 SHALL have port p_rdata, output, 8, read byte shared by both ports.
REQ-010 SHALL have port p_rvalid, output, 2, one-cycle read-data-valid pulse to the owning port.
REQ-011 SHALL have sdram_controller-side ports: sd_wr_addr, sd_rd_addr (HADDR_WIDTH, out); sd_wr_data (8, out); sd_wr_enable, sd_rd_enable (1, out); sd_ack, sd_rd_ready, sd_busy (1, in); sd_rd_data (8, in).

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT_RD.
REQ-013 IDLE: if any p_req, SHALL pick winner, latch grant, we, addr, wdata, and enter ISSUE next cycle; else stay IDLE.
REQ-014 ISSUE: SHALL drive sd_rd_enable or sd_wr_enable per latched we, with addr/data on both address buses, held until sd_ack.
REQ-015 p_ack[grant] SHALL be combinational: state==ISSUE && sd_ack; this is the only cycle it is high.
REQ-016 On sd_ack SHALL deassert both sd_*_enable at the next edge; write -> IDLE, read -> WAIT_RD.
REQ-017 WAIT_RD: on sd_rd_ready SHALL register sd_rd_data into p_rdata, pulse p_rvalid[grant] next cycle, return to IDLE.
REQ-018 p_rdata SHALL hold its value until the next read completes.
REQ-019 SHALL ignore sd_ack outside ISSUE and sd_rd_ready outside WAIT_RD.
REQ-020 SHALL never have more than one transaction outstanding; requests arriving in ISSUE or WAIT_RD wait, with no loss.
REQ-021 sd_busy SHALL NOT gate issue; the controller's ack alone governs acceptance, including across refresh.
REQ-022 Request deasserted by a requester before p_ack is illegal; the latched transaction SHALL complete regardless.

Reset
REQ-023 rst SHALL force state IDLE, grant 0, last-grant pointer 1, sd_rd_enable=sd_wr_enable=0, p_rvalid=0, p_rdata=0, latched addr/data=0.
REQ-024 rst mid-transaction SHALL abandon it with no p_ack or p_rvalid; the controller is reset alongside it.

Configuration
REQ-025 With SDRAM_ARB_RR_EN defined, SHALL use round-robin: on simultaneous requests, the port not granted last wins; the pointer updates on each grant.
REQ-026 Without SDRAM_ARB_RR_EN, SHALL use fixed priority, port 0 always wins; the pointer is absent.

Structure
REQ-027 Shared package sdram_pkg SHALL hold the FSM state encodings, the port count (2), and HADDR_WIDTH default.
REQ-028 Sub-module sdram_arb_pick SHALL hold the combinational winner selection: inputs req and last grant, output grant index.

Verification
REQ-029 Port 0 write addr 0x0000123, data 0xA5 -> sd_wr_enable high until sd_ack, p_ack[0] in the same cycle as sd_ack, back to IDLE, no p_rvalid.
REQ-030 Port 1 read addr 0x1ABCDEF, sd_rd_data=0x3C with sd_rd_ready -> p_rvalid[1] one cycle later, p_rdata=0x3C, p_rvalid[0] stays 0.
REQ-031 Both ports request continuously with RR -> grants alternate 0,1,0,1 over 4 transactions; without the macro -> 4 grants to port 0.
REQ-032 Port 1 requests while port 0's read sits in WAIT_RD -> sd_rd_enable stays low until port 0's p_rvalid, then port 1 issues.
REQ-033 sd_ack delayed 40 cycles, mimicking a refresh -> enable held 40 cycles, a single p_ack, no duplicate issue.
REQ-034 rst asserted in WAIT_RD -> outputs go to reset values immediately, no p_rvalid, the next request is served normally.
